// File: rtl/csr_file_tmr.sv
// Control/status register file with exception capture, ertn restore, interrupt merge
// and a TCFG/TVAL/TICLR countdown timer. Read port is combinational.
//
// state  | meaning
// T_IDLE | timer disabled, TVAL holds
// T_RUN  | TVAL counting down, fires IS[11] on reaching zero
// T_DONE | one-shot expired, TVAL parked at zero
module csr_file_tmr #(
    parameter int          SAVE_NUM = 4,
    parameter int          TIMER_W  = 32,
    parameter logic [31:0] TID_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] raddr,
    output logic [31:0] rdata,
    input  logic [1:0]  we,
    input  logic [13:0] waddr,
    input  logic [31:0] wdata,
    input  logic [31:0] rj_value,
    input  logic [31:0] pc,
    input  logic        is_exc,
    input  logic        is_ret,
    input  logic [5:0]  Ecode,
    input  logic [8:0]  EsubCode,
    input  logic        badv_we,
    input  logic [31:0] badv_addr,
    input  logic [7:0]  hw_int,
    output logic        has_int,
    output logic [31:0] ERA,
    output logic [31:0] EENTRY
);

    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_BADV   = 14'h007;
    localparam logic [13:0] A_EENTRY = 14'h00C;
    localparam logic [13:0] A_SAVE0  = 14'h030;
    localparam logic [13:0] A_TID    = 14'h040;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} tstate_t;

    tstate_t state, state_next;

    logic [8:0]         crmd;
    logic [2:0]         prmd;
    logic [12:0]        ecfg;
    logic [1:0]         estat_sw;
    logic [7:0]         estat_hw;
    logic               estat_ti;
    logic [5:0]         ecode_q;
    logic [8:0]         esubcode_q;
    logic [31:0]        era;
    logic [31:0]        badv;
    logic [25:0]        eentry;
    logic [31:0]        tid;
    logic [31:0]        save [SAVE_NUM];
    logic [TIMER_W-1:0] tcfg;
    logic [TIMER_W-1:0] cnt, cnt_next;
    logic               timer_fire;

    logic [31:0]        estat;
    logic [31:0]        wold, wval;
    logic               wr_act, tcfg_wr, ticlr_clr;
    logic [TIMER_W-1:0] init_cur, init_new;

    assign estat = {1'b0, esubcode_q, ecode_q, 3'b000, 1'b0, estat_ti, 1'b0, estat_hw, estat_sw};

    function automatic logic [31:0] csr_read(input logic [13:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            A_CRMD:   v = {23'b0, crmd};
            A_PRMD:   v = {29'b0, prmd};
            A_ECFG:   v = {19'b0, ecfg};
            A_ESTAT:  v = estat;
            A_ERA:    v = era;
            A_BADV:   v = badv;
            A_EENTRY: v = {eentry, 6'b0};
            A_TID:    v = tid;
            A_TCFG:   v = 32'(tcfg);
            A_TVAL:   v = 32'(cnt);
            default:  v = '0;
        endcase
        for (int k = 0; k < SAVE_NUM; k++) begin
            if (a == A_SAVE0 + 14'(k)) v = save[k];
        end
        return v;
    endfunction

    assign rdata  = csr_read(raddr);
    assign wold   = csr_read(waddr);
    assign ERA    = era;
    assign EENTRY = {eentry, 6'b0};

    // csrxchg merges through rj_value; a simultaneous csrwr takes the full value
    assign wval      = we[0] ? wdata : ((wold & ~rj_value) | (wdata & rj_value));
    assign wr_act    = (|we) & ~is_exc & ~is_ret;
    assign tcfg_wr   = wr_act && (waddr == A_TCFG);
    assign ticlr_clr = wr_act && (waddr == A_TICLR) && wval[0];
    assign init_cur  = {tcfg[TIMER_W-1:2], 2'b00};
    assign init_new  = {wval[TIMER_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= T_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        timer_fire = 1'b0;
        if (tcfg_wr) begin
            if (wval[0]) begin
                cnt_next   = init_new;
                state_next = T_RUN;
            end else begin
                state_next = T_IDLE;
            end
        end else if (state == T_RUN) begin
            if (cnt != '0) begin
                cnt_next = cnt - {{(TIMER_W-1){1'b0}}, 1'b1};
            end else begin
                timer_fire = 1'b1;
                if (tcfg[1]) cnt_next   = init_cur;
                else         state_next = T_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crmd       <= 9'h008;
            prmd       <= '0;
            ecfg       <= '0;
            estat_sw   <= '0;
            estat_hw   <= '0;
            estat_ti   <= 1'b0;
            ecode_q    <= '0;
            esubcode_q <= '0;
            era        <= '0;
            badv       <= '0;
            eentry     <= '0;
            tid        <= TID_INIT;
            tcfg       <= '0;
            cnt        <= '0;
            has_int    <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            estat_hw <= hw_int;
            // expiry beats a same-cycle TICLR so no tick is lost
            if (timer_fire)     estat_ti <= 1'b1;
            else if (ticlr_clr) estat_ti <= 1'b0;
            has_int <= crmd[2] & (|(estat[12:0] & ecfg));
            if (is_exc) begin
                prmd       <= crmd[2:0];
                crmd[2:0]  <= 3'b000;
                era        <= pc;
                ecode_q    <= Ecode;
                esubcode_q <= EsubCode;
                if (badv_we) badv <= badv_addr;
            end else if (is_ret) begin
                crmd[2:0] <= prmd;
            end else if (wr_act) begin
                case (waddr)
                    A_CRMD:   crmd     <= wval[8:0];
                    A_PRMD:   prmd     <= wval[2:0];
                    A_ECFG:   ecfg     <= wval[12:0] & 13'h1BFF;
                    A_ESTAT:  estat_sw <= wval[1:0];
                    A_ERA:    era      <= wval;
                    A_BADV:   badv     <= wval;
                    A_EENTRY: eentry   <= wval[31:6];
                    A_TID:    tid      <= wval;
                    A_TCFG:   tcfg     <= wval[TIMER_W-1:0];
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SAVE_NUM; k++) save[k] <= '0;
        end else if (wr_act) begin
            for (int k = 0; k < SAVE_NUM; k++) begin
                if (waddr == A_SAVE0 + 14'(k)) save[k] <= wval;
            end
        end
    end

endmodule
